// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, display-enable,
// active-region coordinates and line/frame start strobes, all advancing on ce.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          dclk,
    input  logic          clr,
    input  logic          ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_AS    = H_SYNC + H_BP;
    localparam int H_AE    = H_AS + H_ACTIVE;
    localparam int V_AS    = V_SYNC + V_BP;
    localparam int V_AE    = V_AS + V_ACTIVE;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    if ((H_TOTAL - 1) >= (2 ** CW) || (V_TOTAL - 1) >= (2 ** CW)) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] hc, vc;
    logic [CW-1:0] hc_n, vc_n, x_n, y_n;
    logic          h_wrap, v_wrap, h_act_n, v_act_n;

    // Outputs decode the counter values being loaded on this edge, so they never lag hc/vc.
    always_comb begin
        h_wrap  = (hc == H_LAST);
        v_wrap  = (vc == V_LAST);
        hc_n    = h_wrap ? '0 : hc + 1'b1;
        vc_n    = vc;
        if (h_wrap) begin
            vc_n = v_wrap ? '0 : vc + 1'b1;
        end
        h_act_n = (int'(hc_n) >= H_AS) && (int'(hc_n) < H_AE);
        v_act_n = (int'(vc_n) >= V_AS) && (int'(vc_n) < V_AE);
        x_n     = h_act_n ? CW'(int'(hc_n) - H_AS) : '0;
        y_n     = v_act_n ? CW'(int'(vc_n) - V_AS) : '0;
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            hc          <= '0;
            vc          <= '0;
            hsync       <= HS_POL;
            vsync       <= VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hc          <= hc_n;
            vc          <= vc_n;
            hsync       <= (int'(hc_n) < H_SYNC) ? HS_POL : ~HS_POL;
            vsync       <= (int'(vc_n) < V_SYNC) ? VS_POL : ~VS_POL;
            de          <= h_act_n & v_act_n;
            x           <= x_n;
            y           <= y_n;
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end else begin
            // Strobes are one dclk wide even when ce is sparse.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
